box_slave: RTL

//  AXI write responder. Terminating end of the link driven by box_master.

---
 rtl/box_slave_pkg.sv | 46 ++++
 rtl/box_slave_pack.sv | 74 +++++++
 rtl/box_slave.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/box_slave_pkg.sv
// Shared types for the box_master -> box_slave write link: header and
// reassembled-burst layouts, B response codes and the responder FSM encoding.
package box_slave_pkg;

    localparam int DATA_W      = 32;               // bits per W beat
    localparam int LEN_W       = 4;                // awlen / beat counter width
    localparam int ID_W        = 4;                // awid / wid / bid width
    localparam int STRB_W      = DATA_W / 8;       // byte strobes per beat
    localparam int MAX_BEATS   = 2 ** LEN_W;       // longest burst
    localparam int SLOT_DATA_W = MAX_BEATS * DATA_W;
    localparam int SLOT_STRB_W = MAX_BEATS * STRB_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AW header as launched by box_master
    typedef struct packed {
        logic [ID_W-1:0]  awid;
        logic [31:0]      awaddr;
        logic [LEN_W-1:0] awlen;
        logic [2:0]       awsize;
        logic [1:0]       awburst;
        logic [3:0]       awuser;
        logic [7:0]       other;
    } aw_hdr_t;

    // Whole burst: header plus every beat packed low slice first
    typedef struct packed {
        aw_hdr_t                hdr;
        logic [SLOT_DATA_W-1:0] data;
        logic [SLOT_STRB_W-1:0] strb;
    } burst_slot;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_OUT  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // B response for a burst given its sticky error flag
    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/box_slave_pack.sv
// Beat counter and slot storage. Each accepted beat lands in the slice
// selected by the beat counter; a header capture zero-fills every slice
// not written in that same cycle so short bursts leave no stale data.
module box_slave_pack
    import box_slave_pkg::*;
#(
    parameter int PDATA_WIDTH   = DATA_W,
    parameter int PLENGTH_WIDTH = LEN_W
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         clear,
    input  logic                                         beat_en,
    input  logic                                         final_beat,
    input  logic [PDATA_WIDTH-1:0]                       wdata,
    input  logic [PDATA_WIDTH/8-1:0]                     wstrb,
    output logic [PLENGTH_WIDTH-1:0]                     beat_cnt,
    output logic [(2**PLENGTH_WIDTH)*PDATA_WIDTH-1:0]    data,
    output logic [(2**PLENGTH_WIDTH)*(PDATA_WIDTH/8)-1:0] strb
);

    localparam int NSLICE = 2 ** PLENGTH_WIDTH;
    localparam int SW     = PDATA_WIDTH / 8;

    logic [PLENGTH_WIDTH-1:0] wr_idx;
    logic [NSLICE-1:0]        slice_we;

    // Beat 0 can arrive with the header, before the counter is rewound,
    // so a capture always writes slice 0.
    always_comb begin
        wr_idx = beat_cnt;
        if (clear) begin
            wr_idx = '0;
        end
    end

    // One-hot write enable for the addressed slice
    always_comb begin
        slice_we = '0;
        if (beat_en) begin
            slice_we[wr_idx] = 1'b1;
        end
    end

    // Beat counter: restarts on capture, wraps to 0 after the final beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= (beat_en && !final_beat) ? PLENGTH_WIDTH'(1) : '0;
        end else if (beat_en) begin
            beat_cnt <= final_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Slice storage: write the addressed slice, zero the rest on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            strb <= '0;
        end else begin
            for (int i = 0; i < NSLICE; i++) begin
                if (slice_we[i]) begin
                    data[i*PDATA_WIDTH +: PDATA_WIDTH] <= wdata;
                    strb[i*SW +: SW]                   <= wstrb;
                end else if (clear) begin
                    data[i*PDATA_WIDTH +: PDATA_WIDTH] <= '0;
                    strb[i*SW +: SW]                   <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/box_slave.sv
// AXI write responder terminating the box_master link. Takes one AW header
// and its W beats, reassembles them into a burst_slot, hands the slot
// downstream, then answers with a single B response. One burst in flight.
//
// Handshakes: every channel transfers on a cycle where valid && ready are
// both high at the rising clock edge. A raised valid (out_valid, bvalid)
// stays high with its payload unchanged until that transfer happens, and
// valid never depends on ready.
module box_slave
    import box_slave_pkg::*;
#(
    parameter int PDATA_WIDTH   = DATA_W,
    parameter int PLENGTH_WIDTH = LEN_W,
    parameter int ID_WIDTH      = ID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     awvalid,
    output logic                     awready,
    input  aw_hdr_t                  aw_hdr,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [ID_WIDTH-1:0]      wid,
    input  logic [PDATA_WIDTH-1:0]   wdata,
    input  logic [PDATA_WIDTH/8-1:0] wstrb,
    input  logic                     wlast,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [ID_WIDTH-1:0]      bid,
    output logic [1:0]               bresp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output burst_slot                out_slot,
    output logic                     proto_err
);

    // FSM state is kept in one named enum register for observation
    state_t                   state;
    state_t                   state_nxt;
    aw_hdr_t                  hdr_r;
    logic                     err_r;

    logic                     capture;
    logic                     beat_take;
    logic                     final_beat;
    logic                     viol;
    logic [ID_WIDTH-1:0]      cur_id;
    logic [PLENGTH_WIDTH-1:0] cur_len;
    logic [PLENGTH_WIDTH-1:0] beat_cnt;
    logic [SLOT_DATA_W-1:0]   slot_data;
    logic [SLOT_STRB_W-1:0]   slot_strb;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and channel handshake outputs
    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        wready    = 1'b0;
        out_valid = 1'b0;
        bvalid    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Beat 0 rides along with the header
                awready = 1'b1;
                wready  = awvalid;
                if (awvalid) begin
                    capture   = 1'b1;
                    state_nxt = (wvalid && (aw_hdr.awlen == '0)) ? ST_OUT : ST_DATA;
                end
            end
            ST_DATA: begin
                wready = 1'b1;
                if (wvalid && final_beat) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Beat context and protocol checks. In IDLE the header is still on the
    // input bus, afterwards it comes from the captured copy. Completion is
    // counted from awlen; wlast is only checked, never trusted.
    always_comb begin
        cur_id  = hdr_r.awid;
        cur_len = hdr_r.awlen;
        if (state == ST_IDLE) begin
            cur_id  = aw_hdr.awid;
            cur_len = aw_hdr.awlen;
        end
        beat_take  = wvalid && wready;
        final_beat = (state == ST_IDLE) ? (cur_len == '0) : (beat_cnt == cur_len);
        viol       = beat_take &&
                     ((wid != cur_id) ||
                      (wlast && !final_beat) ||
                      (!wlast && final_beat && (cur_len != '0)));
    end

    // Header capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_r <= '0;
        end else if (capture) begin
            hdr_r <= aw_hdr;
        end
    end

    // Sticky burst error, released once the B response has been taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state == ST_RESP) && bready) begin
            err_r <= 1'b0;
        end else if (viol) begin
            err_r <= 1'b1;
        end
    end

    box_slave_pack #(
        .PDATA_WIDTH   (PDATA_WIDTH),
        .PLENGTH_WIDTH (PLENGTH_WIDTH)
    ) u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (capture),
        .beat_en    (beat_take),
        .final_beat (final_beat),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .beat_cnt   (beat_cnt),
        .data       (slot_data),
        .strb       (slot_strb)
    );

    // Slot, B payload and error pulse
    always_comb begin
        out_slot      = '0;
        out_slot.hdr  = hdr_r;
        out_slot.data = slot_data;
        out_slot.strb = slot_strb;
        bid           = hdr_r.awid;
        bresp         = bvalid ? resp_code(err_r) : RESP_OKAY;
        proto_err     = viol;
    end

endmodule
